// File: rtl/memc_pkg.sv
// memc_pkg: shared encodings, default widths and response bundle
// for the memory-controller load/store responder.
package memc_pkg;

   localparam int MEMC_ADDR_W = 24;
   localparam int MEMC_DATA_W = 32;
   localparam int MEMC_TAG_W  = 4;

   localparam logic [1:0] MEMC_REQ_READ   = 2'b01;
   localparam logic [1:0] MEMC_REQ_WRITE  = 2'b10;

   localparam logic [1:0] MEMC_RESP_RDATA = 2'b01;
   localparam logic [1:0] MEMC_RESP_WACK  = 2'b10;
   localparam logic [1:0] MEMC_RESP_ERR   = 2'b11;

   typedef struct packed {
      logic [1:0]             cntl;
      logic [MEMC_TAG_W-1:0]  tag;
      logic [MEMC_DATA_W-1:0] data;
   } memc_resp_t;

   function automatic logic [1:0] memc_resp_code(
      input logic [1:0] req
   );
      logic [1:0] code;
      case (req)
         MEMC_REQ_READ:  code = MEMC_RESP_RDATA;
         MEMC_REQ_WRITE: code = MEMC_RESP_WACK;
         default:        code = MEMC_RESP_ERR;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/memc_resp_fifo.sv
// memc_resp_fifo: synchronous FIFO holding tagged responses.
// Ports: clk, reset_poweron (async, active low), i_push/i_data,
// i_pop, o_data (head), o_empty, o_full. Push+pop allowed when full.
module memc_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_poweron,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_cnt;
   logic             w_do_pop;
   logic             w_do_push;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign o_empty   = (r_cnt == '0);
   assign o_full    = (r_cnt == CW'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   // a full FIFO still takes a push when its head leaves this cycle
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= nxt(r_wr);
         if (w_do_pop)  r_rd <= nxt(r_rd);
         if (w_do_push & ~w_do_pop)
            r_cnt <= r_cnt + CW'(1);
         else if (~w_do_push & w_do_pop)
            r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/memc_load_store_responder.sv
// memc_load_store_responder: accepts LD/ST requests, runs them on a
// single-port SRAM and returns in-order tagged responses.
// Ports: ldst__memc__* request, memc__ldst__resp_* response,
// sram_* local memory, clk / reset_poweron (async, active low).
module memc_load_store_responder
   import memc_pkg::*;
#(
   parameter int ADDR_WIDTH      = MEMC_ADDR_W,
   parameter int DATA_WIDTH      = MEMC_DATA_W,
   parameter int TAG_WIDTH       = MEMC_TAG_W,
   parameter int RESP_FIFO_DEPTH = 4,
   parameter int SRAM_RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_poweron,
   input  logic                  ldst__memc__valid,
   input  logic [1:0]            ldst__memc__cntl,
   input  logic [TAG_WIDTH-1:0]  ldst__memc__tag,
   input  logic [ADDR_WIDTH-1:0] ldst__memc__address,
   input  logic [DATA_WIDTH-1:0] ldst__memc__data,
   output logic                  memc__ldst__ready,
   output logic                  memc__ldst__resp_valid,
   output logic [1:0]            memc__ldst__resp_cntl,
   output logic [TAG_WIDTH-1:0]  memc__ldst__resp_tag,
   output logic [DATA_WIDTH-1:0] memc__ldst__resp_data,
   input  logic                  ldst__memc__resp_ready,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata
);

   localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);
   localparam int L  = SRAM_RD_LATENCY;
   localparam int RW = 2 + TAG_WIDTH + DATA_WIDTH;

   typedef struct packed {
      logic [1:0]            cntl;
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } resp_t;

   logic [CW-1:0]        r_outstanding;
   logic                 r_pv [L];
   logic [1:0]           r_pc [L];
   logic [TAG_WIDTH-1:0] r_pt [L];

   logic  w_accept;
   logic  w_pop;
   logic  w_push;
   logic  w_rd;
   logic  w_wr;
   logic  w_empty;
   logic  w_full;
   resp_t w_push_data;
   resp_t w_head;

   // ready is low while reset is held, high from the first
   // cycle after release
   assign memc__ldst__ready = reset_poweron &
      (r_outstanding < CW'(RESP_FIFO_DEPTH));

   assign w_accept = ldst__memc__valid & memc__ldst__ready;
   assign w_pop    = memc__ldst__resp_valid & ldst__memc__resp_ready;
   assign w_rd     = (ldst__memc__cntl == MEMC_REQ_READ);
   assign w_wr     = (ldst__memc__cntl == MEMC_REQ_WRITE);

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         r_outstanding <= '0;
      end else if (w_accept & ~w_pop) begin
         r_outstanding <= r_outstanding + CW'(1);
      end else if (~w_accept & w_pop) begin
         r_outstanding <= r_outstanding - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_en <= w_accept & (w_rd | w_wr);
         sram_we <= w_accept & w_wr;
         if (w_accept & (w_rd | w_wr))
            sram_addr <= ldst__memc__address;
         if (w_accept & w_wr)
            sram_wdata <= ldst__memc__data;
      end
   end

   // every accepted request rides the pipe, so responses keep order
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         for (int i = 0; i < L; i++) begin
            r_pv[i] <= 1'b0;
            r_pc[i] <= '0;
            r_pt[i] <= '0;
         end
      end else begin
         r_pv[0] <= w_accept;
         r_pc[0] <= ldst__memc__cntl;
         r_pt[0] <= ldst__memc__tag;
         for (int i = 1; i < L; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pc[i] <= r_pc[i-1];
            r_pt[i] <= r_pt[i-1];
         end
      end
   end

   always_comb begin
      w_push_data      = '0;
      w_push_data.cntl = memc_resp_code(r_pc[L-1]);
      w_push_data.tag  = r_pt[L-1];
      if (r_pc[L-1] == MEMC_REQ_READ)
         w_push_data.data = sram_rdata;
   end

   // credits keep this from ever blocking; it only guards the FIFO
   assign w_push = r_pv[L-1] & (~w_full | w_pop);

   memc_resp_fifo #(
      .WIDTH (RW),
      .DEPTH (RESP_FIFO_DEPTH)
   ) u_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .i_push        (w_push),
      .i_data        (w_push_data),
      .i_pop         (w_pop),
      .o_data        (w_head),
      .o_empty       (w_empty),
      .o_full        (w_full)
   );

   assign memc__ldst__resp_valid = ~w_empty;
   assign memc__ldst__resp_cntl  = w_empty ? '0 : w_head.cntl;
   assign memc__ldst__resp_tag   = w_empty ? '0 : w_head.tag;
   assign memc__ldst__resp_data  = w_empty ? '0 : w_head.data;

endmodule
